// File: rtl/lpddr2_avl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lpddr2_avl_pkg
// Description : Shared types and constants for the LPDDR2 Avalon-MM responder.
//               Holds the responder state encoding, the only legal Avalon
//               burst size and the default interface widths.
// Revision    : 1.0 - initial release
// ============================================================================
package lpddr2_avl_pkg;

  // Controller-visible phases: calibration delay, normal service, refresh stall
  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_REFRESH = 2'd2
  } resp_state_t;

  localparam logic [2:0] AVL_SIZE_SINGLE = 3'd1;

  localparam int DEF_ADDR_W     = 27;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_DEPTH_LOG2 = 10;

endpackage : lpddr2_avl_pkg
`default_nettype wire

// File: rtl/avl_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : avl_rd_pipe
// Description : Fixed-latency read-return pipeline. LATENCY stages of
//               {valid, data}. A stage only captures data when the stage
//               ahead of it holds a valid word, so the output data holds the
//               last returned word while valid is low.
// Ports       : clk_i   - clock
//               rst_ni  - asynchronous active-low reset
//               push_i  - a read word enters the pipe this edge
//               data_i  - read word to push
//               valid_o - read data valid (one pulse per pushed word)
//               data_o  - read data
// Revision    : 1.0 - initial release
// ============================================================================
module avl_rd_pipe #(
  parameter int LATENCY = 4,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              vld_q [LATENCY];
  logic [DATA_W-1:0] dat_q [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= push_i;
      if (push_i) begin
        dat_q[0] <= data_i;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign valid_o = vld_q[LATENCY-1];
  assign data_o  = dat_q[LATENCY-1];

endmodule : avl_rd_pipe
`default_nettype wire

// File: rtl/lpddr2_avl_responder.sv
`default_nettype none
// ============================================================================
// Module      : lpddr2_avl_responder
// Description : Avalon-MM stand-in for the LPDDR2 controller port 0. Serves
//               commands from an on-chip RAM with fixed read latency and
//               mimics the controller's init delay, refresh stalls and
//               pipelined read-data-valid.
// Ports       : iCLK / iRST_n       - clock, async active-low reset
//               avl_addr            - word address (low DEPTH_LOG2 bits used)
//               avl_read_req        - read request
//               avl_write_req       - write request
//               avl_wdata / avl_be  - write data and byte enables
//               avl_size            - burst size (only 1 supported)
//               avl_burstbegin      - accepted, ignored
//               avl_ready           - command accept (state RUN)
//               avl_rdata(_valid)   - read return
//               local_init_done     - init complete
//               local_cal_success   - mirror of local_init_done
//               proto_err           - sticky protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module lpddr2_avl_responder
  import lpddr2_avl_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int DEPTH_LOG2     = DEF_DEPTH_LOG2,
  parameter int READ_LATENCY   = 4,
  parameter int INIT_CYCLES    = 16,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_LEN    = 3
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  input  logic [ADDR_W-1:0]   avl_addr,
  input  logic                avl_read_req,
  input  logic                avl_write_req,
  input  logic [DATA_W-1:0]   avl_wdata,
  input  logic [DATA_W/8-1:0] avl_be,
  input  logic [2:0]          avl_size,
  input  logic                avl_burstbegin,
  output logic                avl_ready,
  output logic [DATA_W-1:0]   avl_rdata,
  output logic                avl_rdata_valid,
  output logic                local_init_done,
  output logic                local_cal_success,
  output logic                proto_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  // Terminal counts; the refresh one is only used when refresh is enabled
  localparam logic [31:0] INIT_LAST = 32'(INIT_CYCLES - 1);
  localparam logic [31:0] REF_LAST  = 32'(REFRESH_PERIOD - 1);
  localparam logic [31:0] RFL_LAST  = 32'(REFRESH_LEN - 1);

  resp_state_t state_q, state_d;
  logic [31:0] init_cnt_q, init_cnt_d;
  logic [31:0] ref_cnt_q, ref_cnt_d;
  logic [31:0] rfl_cnt_q, rfl_cnt_d;
  logic        proto_err_q;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  cmd_acc;
  logic                  wr_acc;
  logic                  rd_push;
  logic                  cmd_bad;
  logic                  w_unused;

  // --------------------------------------------------------------------------
  // Phase FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ref_cnt_q  <= '0;
      rfl_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      rfl_cnt_q  <= rfl_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ref_cnt_d  = ref_cnt_q;
    rfl_cnt_d  = rfl_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 32'd1;
        end
      end
      ST_RUN: begin
        // A zero period disables refresh: stay in RUN forever
        if (REFRESH_PERIOD != 0) begin
          if (ref_cnt_q == REF_LAST) begin
            state_d   = ST_REFRESH;
            ref_cnt_d = '0;
          end else begin
            ref_cnt_d = ref_cnt_q + 32'd1;
          end
        end
      end
      ST_REFRESH: begin
        if (rfl_cnt_q == RFL_LAST) begin
          state_d   = ST_RUN;
          rfl_cnt_d = '0;
        end else begin
          rfl_cnt_d = rfl_cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Ready is a pure function of state so a stalled master cannot form a loop
  assign avl_ready         = (state_q == ST_RUN);
  assign local_init_done   = (state_q != ST_INIT);
  assign local_cal_success = local_init_done;

  // --------------------------------------------------------------------------
  // Command decode
  // --------------------------------------------------------------------------
  assign ram_idx = avl_addr[DEPTH_LOG2-1:0];
  assign cmd_acc = avl_ready && (avl_read_req || avl_write_req);
  assign wr_acc  = cmd_acc && avl_write_req;
  // A read that collides with a write is dropped; the write wins
  assign rd_push = cmd_acc && avl_read_req && !avl_write_req;
  assign cmd_bad = (avl_read_req && avl_write_req) || (avl_size != AVL_SIZE_SINGLE);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      proto_err_q <= 1'b0;
    end else if (cmd_acc && cmd_bad) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;

  // --------------------------------------------------------------------------
  // Backing RAM (contents deliberately not reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (wr_acc) begin
      for (int b = 0; b < BE_W; b++) begin
        if (avl_be[b]) begin
          mem_q[ram_idx][b*8 +: 8] <= avl_wdata[b*8 +: 8];
        end
      end
    end
  end

  // The word is sampled at the accept edge; a write on the previous edge has
  // already landed, which gives read-after-write without a bypass path.
  avl_rd_pipe #(
    .LATENCY (READ_LATENCY),
    .DATA_W  (DATA_W)
  ) u_rd_pipe (
    .clk_i   (iCLK),
    .rst_ni  (iRST_n),
    .push_i  (rd_push),
    .data_i  (mem_q[ram_idx]),
    .valid_o (avl_rdata_valid),
    .data_o  (avl_rdata)
  );

  // Address bits above the RAM index alias; burstbegin carries no meaning here
  assign w_unused = ^{avl_burstbegin, avl_addr};

endmodule : lpddr2_avl_responder
`default_nettype wire

// File: tb/tb_lpddr2_avl_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lpddr2_avl_responder
// Description : Directed self-checking bench for lpddr2_avl_responder. Read
//               results are queued with their due cycle when a read is
//               accepted and compared when avl_rdata_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lpddr2_avl_responder;

  localparam int RL  = 4;
  localparam int INI = 16;
  localparam int P   = 64;
  localparam int L   = 3;

  logic        clk = 1'b0;
  logic        iRST_n = 1'b0;
  logic [26:0] avl_addr = '0;
  logic        avl_read_req = 1'b0;
  logic        avl_write_req = 1'b0;
  logic [31:0] avl_wdata = '0;
  logic [3:0]  avl_be = '0;
  logic [2:0]  avl_size = 3'd1;
  logic        avl_burstbegin = 1'b0;
  logic        avl_ready;
  logic [31:0] avl_rdata;
  logic        avl_rdata_valid;
  logic        local_init_done;
  logic        local_cal_success;
  logic        proto_err;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  lpddr2_avl_responder #(
    .ADDR_W(27), .DATA_W(32), .DEPTH_LOG2(10), .READ_LATENCY(RL),
    .INIT_CYCLES(INI), .REFRESH_PERIOD(P), .REFRESH_LEN(L)
  ) dut (
    .iCLK(clk), .iRST_n(iRST_n), .avl_addr(avl_addr),
    .avl_read_req(avl_read_req), .avl_write_req(avl_write_req),
    .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_size(avl_size),
    .avl_burstbegin(avl_burstbegin), .avl_ready(avl_ready),
    .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid),
    .local_init_done(local_init_done), .local_cal_success(local_cal_success),
    .proto_err(proto_err)
  );

  // cyc = number of rising edges since reset release
  always @(posedge clk or negedge iRST_n) begin
    if (!iRST_n) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready(input int c);
    return (c >= INI) && (((c - INI) % (P + L)) < P);
  endfunction

  // Monitor: ready pattern, init flags and read returns against the scoreboard
  always @(negedge clk) begin
    if (iRST_n) begin
      chk("ready", {31'b0, avl_ready}, {31'b0, exp_ready(cyc)});
      chk("init_done", {31'b0, local_init_done}, {31'b0, cyc >= INI});
      chk("cal_success", {31'b0, local_cal_success}, {31'b0, cyc >= INI});
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("missing_valid", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (avl_rdata_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {31'b0, avl_rdata_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_data", avl_rdata, e.data);
          chk("rd_due", cyc, e.due);
        end
      end
    end
  end

  // Present a command at posedge+1, hold until accepted; n = accept edge
  task automatic issue(input logic rd, input logic wr, input logic [26:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input logic [2:0] sz, output int n);
    avl_read_req = rd; avl_write_req = wr; avl_addr = a;
    avl_wdata = d; avl_be = be; avl_size = sz; avl_burstbegin = 1'b1;
    for (int k = 0; k < 100 && !avl_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!avl_ready) chk("accept_timeout", {31'b0, avl_ready}, 32'd1);
    n = cyc + 1;
    @(posedge clk); #1;
    avl_read_req = 1'b0; avl_write_req = 1'b0; avl_burstbegin = 1'b0;
    avl_size = 3'd1;
  endtask

  task automatic wr_cmd(input logic [26:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [2:0] sz);
    int n;
    issue(1'b0, 1'b1, a, d, be, sz, n);
  endtask

  task automatic rd_cmd(input logic [26:0] a, input logic [31:0] exp, output int n);
    exp_t e;
    issue(1'b1, 1'b0, a, 32'h0, 4'h0, 3'd1, n);
    e.data = exp;
    e.due  = n + RL - 1;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() > 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic wait_phase(input int ph);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (cyc >= INI && ((cyc - INI) % (P + L)) == ph) break;
    end
  endtask

  task automatic wait_init();
    for (int k = 0; k < 40 && cyc < INI - 1; k++) begin
      @(posedge clk); #1;
    end
    chk("pre_init_ready", {31'b0, avl_ready}, 32'd0);
    chk("pre_init_done", {31'b0, local_init_done}, 32'd0);
    @(posedge clk); #1;
    chk("init_edge_ready", {31'b0, avl_ready}, 32'd1);
    chk("init_edge_done", {31'b0, local_init_done}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'b0, avl_ready}, 32'd0);
    chk({tag, "_valid"}, {31'b0, avl_rdata_valid}, 32'd0);
    chk({tag, "_rdata"}, avl_rdata, 32'd0);
    chk({tag, "_init"}, {31'b0, local_init_done}, 32'd0);
    chk({tag, "_cal"}, {31'b0, local_cal_success}, 32'd0);
    chk({tag, "_perr"}, {31'b0, proto_err}, 32'd0);
  endtask

  initial begin
    int n, s;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk); iRST_n = 1'b1;
    @(posedge clk); #1;
    wait_init();

    // write then read next cycle
    wr_cmd(27'd5, 32'hDEADBEEF, 4'hF, 3'd1);
    rd_cmd(27'd5, 32'hDEADBEEF, n);

    // byte enables and address aliasing
    wr_cmd(27'd7, 32'h11223344, 4'hF, 3'd1);
    wr_cmd(27'd7, 32'hAABBCCDD, 4'b0101, 3'd1);
    rd_cmd(27'd7, 32'h11BB33DD, n);
    rd_cmd(27'h407, 32'h11BB33DD, n);
    drain();

    // streaming reads
    for (int i = 0; i < 8; i++) wr_cmd(27'(i), 32'hC0DE0000 + 32'(i), 4'hF, 3'd1);
    for (int i = 0; i < 8; i++) rd_cmd(27'(i), 32'hC0DE0000 + 32'(i), n);
    drain();
    chk("perr_clean", {31'b0, proto_err}, 32'd0);

    // refresh stall: two reads in flight across the stall, one held through it
    wait_phase(P - 2);
    rd_cmd(27'd5, 32'hC0DE0005, n);
    rd_cmd(27'd7, 32'hC0DE0007, n);
    s = cyc;
    chk("stall_ready_low", {31'b0, avl_ready}, 32'd0);
    rd_cmd(27'd2, 32'hC0DE0002, n);
    chk("refresh_accept", n, s + L + 1);
    drain();

    // simultaneous read and write
    issue(1'b1, 1'b1, 27'd3, 32'h55AA55AA, 4'hF, 3'd1, n);
    repeat (RL + 2) @(posedge clk);
    #1;
    chk("perr_rdwr", {31'b0, proto_err}, 32'd1);
    rd_cmd(27'd3, 32'h55AA55AA, n);
    drain();

    // reset with two reads in flight
    rd_cmd(27'd1, 32'hC0DE0001, n);
    rd_cmd(27'd4, 32'hC0DE0004, n);
    iRST_n = 1'b0;
    sb.delete();
    #1;
    chk_reset_outputs("midrst");
    for (int k = 0; k < RL + 2; k++) begin
      @(posedge clk); #1;
      chk("midrst_novalid", {31'b0, avl_rdata_valid}, 32'd0);
    end
    @(negedge clk); iRST_n = 1'b1;
    @(posedge clk); #1;
    wait_init();
    chk("perr_after_rst", {31'b0, proto_err}, 32'd0);

    // unsupported burst size executes as single
    wr_cmd(27'd9, 32'h0BADF00D, 4'hF, 3'd2);
    chk("perr_size", {31'b0, proto_err}, 32'd1);
    rd_cmd(27'd9, 32'h0BADF00D, n);
    drain();
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_lpddr2_avl_responder
`default_nettype wire
